banco_registros: RTL and testbench
==================================

BANCO_REGISTROS -- requirements
Module: banco_registros

Interface
REQ-001 SHALL have parameter N, default 16, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, register count; power of two, >= 4.
REQ-003 SHALL derive localparam A = clog2(DEPTH), the address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port we  input  1  write request.
REQ-007 SHALL have port wr_addr  input  A  write address.
REQ-008 SHALL have port wr_data  input  N  write data.
REQ-009 SHALL have port rd_addr_a  input  A  read port A address.
REQ-010 SHALL have port rd_addr_b  input  A  read port B address.
REQ-011 SHALL have port clr  input  1  request to restore every register to its reset value.
REQ-012 SHALL have port rd_data_a  output  N  read port A data, registered.
REQ-013 SHALL have port rd_data_b  output  N  read port B data, registered.
REQ-014 SHALL have port busy  output  1  restore sequence in progress.
REQ-015 SHALL have port wr_drop  output  1  one-cycle pulse when a we request is discarded.

Function
REQ-016 SHALL use this reset map: reg[0]=2, reg[1]=1, reg[k]=0 for k>=2, each zero-extended to N bits.
REQ-017 SHALL commit wr_data to reg[wr_addr] at the clock edge when we=1 and the state is IDLE.
REQ-018 SHALL present each read port with 1-cycle latency: rd_data_x at edge t+1 reflects reg[rd_addr_x] sampled at edge t.
REQ-019 SHALL serve both read ports independently; equal read addresses return identical data.
REQ-020 SHALL implement an FSM with states IDLE and RESTORE.
REQ-021 SHALL, in IDLE with clr=1, enter RESTORE next cycle with idx=0, and SHALL NOT commit a we asserted in that same cycle; wr_drop=1.
REQ-022 SHALL, in RESTORE, write the reset value to reg[idx] each cycle and increment idx.
REQ-023 SHALL, when idx=DEPTH-1, perform that last write and return to IDLE, so RESTORE lasts exactly DEPTH cycles.
REQ-024 SHALL hold busy=1 exactly while in RESTORE.
REQ-025 SHALL ignore we during RESTORE (no write) and pulse wr_drop=1 for each such cycle.
REQ-026 SHALL ignore clr while in RESTORE; the sequence is not restarted.
REQ-027 SHALL keep reads functional during RESTORE, returning current contents, with restored entries showing reset values.
REQ-028 SHALL hold wr_drop=0 in every cycle where no request is discarded.

Reset
REQ-029 SHALL, while rst=1 and independent of clk, load the reset map into all registers.
REQ-030 SHALL, on reset, force rd_data_a=0, rd_data_b=0, state=IDLE, idx=0, busy=0, wr_drop=0.
REQ-031 SHALL, when rst is asserted mid-RESTORE, abort the sequence with the whole map restored immediately.

Configuration
REQ-032 SHALL implement macro BANCO_REGISTROS_BYPASS_EN.
REQ-033 SHALL, when BANCO_REGISTROS_BYPASS_EN is defined, forward the data committed at edge t (we write or restore write) to any read port whose address matches in that cycle (write-first).
REQ-034 SHALL, when BANCO_REGISTROS_BYPASS_EN is undefined, return the pre-write contents on a same-cycle address match (read-first).

Structure
REQ-035 SHALL place in package banco_registros_pkg: the FSM state encoding (IDLE, RESTORE), the default N and DEPTH, and a function giving the reset value for an index.
REQ-036 SHALL isolate the IDLE/RESTORE FSM and idx counter in sub-module banco_restore_fsm, which outputs busy, idx, restore_we and wr_drop.

Verification
REQ-037 SHALL cover reset check: assert rst, release -> reading addresses 0,1,2,3 gives 2,1,0,0; busy=0.
REQ-038 SHALL cover write then read: we, addr 2, data 0xBEEF; next cycle read A=2, B=2 -> both 0xBEEF after 1 cycle.
REQ-039 SHALL cover same-cycle write/read: we, addr 3, data 0x1234 with rd_addr_a=3 in the same cycle -> rd_data_a=0x1234 with bypass, 0x0000 without.
REQ-040 SHALL cover restore: fill all registers with 0xFFFF, pulse clr -> busy=1 for exactly 4 cycles; afterwards reads give 2,1,0,0.
REQ-041 SHALL cover write during restore: we, addr 1, data 0x5555 while busy -> wr_drop=1 that cycle; reg[1] ends at 1.
REQ-042 SHALL cover async reset mid-restore: assert rst during the 2nd RESTORE cycle -> busy=0 immediately, map 2,1,0,0, rd_data=0.

Source files
------------

// File: rtl/banco_registros_pkg.sv
// Shared definitions for the banco_registros register file: FSM state
// encoding, default geometry and the per-index reset value map.
package banco_registros_pkg;

    localparam int DEFAULT_N     = 16;
    localparam int DEFAULT_DEPTH = 4;

    // Controller states: normal operation, or walking through the register
    // file rewriting every entry with its reset value.
    typedef enum logic {
        IDLE    = 1'b0,
        RESTORE = 1'b1
    } state_t;

    // Reset value of entry 'index'. Only the two low bits can ever be
    // non-zero; callers zero-extend to the data width.
    function automatic logic [1:0] reset_value(input int unsigned index);
        case (index)
            0:       return 2'd2;
            1:       return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/banco_restore_fsm.sv
// IDLE/RESTORE controller for banco_registros. A clr request in IDLE starts
// a DEPTH-cycle sweep; idx names the entry rewritten in each RESTORE cycle.
// Write requests that cannot be honoured (clr cycle or any RESTORE cycle)
// are flagged on wr_drop in the same cycle.
module banco_restore_fsm
    import banco_registros_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int A     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         we,
    output logic         busy,
    output logic [A-1:0] idx,
    output logic         restore_we,
    output logic         wr_drop
);

    state_t         state_q, state_d;
    logic   [A-1:0] idx_q, idx_d;

    // State and sweep index registers; reset parks the controller in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state, sweep progress and per-cycle control outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        busy       = 1'b0;
        restore_we = 1'b0;
        wr_drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    // The write arriving with clr is discarded: the sweep
                    // would overwrite it anyway and it must not be half-applied.
                    state_d = RESTORE;
                    idx_d   = '0;
                    wr_drop = we;
                end
            end
            RESTORE: begin
                busy       = 1'b1;
                restore_we = 1'b1;
                wr_drop    = we;
                // clr is deliberately not looked at here: no restart.
                if (idx_q == A'(DEPTH - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        // Nothing is considered dropped while the block is held in reset.
        wr_drop = wr_drop & ~rst;
    end

    assign idx = idx_q;

endmodule

// File: rtl/banco_registros.sv
// banco_registros: DEPTH x N register file with one write port, two
// registered read ports and a clr-triggered sweep restoring the reset map
// (reg[0]=2, reg[1]=1, others 0).
// Build option: define BANCO_REGISTROS_BYPASS_EN for write-first reads
// (same-cycle committed data forwarded to a matching read port); otherwise
// reads are read-first and return pre-write contents.
module banco_registros
    import banco_registros_pkg::*;
#(
    parameter  int N     = DEFAULT_N,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int A     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [A-1:0] wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [A-1:0] rd_addr_a,
    input  logic [A-1:0] rd_addr_b,
    input  logic         clr,
    output logic [N-1:0] rd_data_a,
    output logic [N-1:0] rd_data_b,
    output logic         busy,
    output logic         wr_drop
);

    logic [N-1:0]     regs_q [DEPTH];
    logic [N-1:0]     rst_word [DEPTH];
    logic [DEPTH-1:0] wr_hit;

    logic [A-1:0]     restore_idx;
    logic             restore_we;

    logic             commit_we;
    logic [A-1:0]     commit_addr;
    logic [N-1:0]     commit_data;

    logic [N-1:0]     rd_data_a_q, rd_data_a_d;
    logic [N-1:0]     rd_data_b_q, rd_data_b_d;

    banco_restore_fsm #(
        .DEPTH (DEPTH)
    ) u_restore_fsm (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .we         (we),
        .busy       (busy),
        .idx        (restore_idx),
        .restore_we (restore_we),
        .wr_drop    (wr_drop)
    );

    // Per-entry constant reset value and write decode.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign rst_word[gi] = N'(reset_value(gi));
        assign wr_hit[gi]   = commit_we && (commit_addr == A'(gi));
    end

    // Select the single write that lands this cycle: the sweep has priority,
    // a user write only lands in IDLE without a concurrent clr.
    always_comb begin
        commit_we   = 1'b0;
        commit_addr = wr_addr;
        commit_data = wr_data;
        if (restore_we) begin
            commit_we   = 1'b1;
            commit_addr = restore_idx;
            commit_data = rst_word[restore_idx];
        end else if (we && !clr && !busy) begin
            commit_we = 1'b1;
        end
    end

    // Storage array; asynchronous reset loads the full map at once, which
    // also aborts any sweep in progress with everything already restored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= rst_word[k];
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (wr_hit[k]) begin
                    regs_q[k] <= commit_data;
                end
            end
        end
    end

    // Read data selection ahead of the output registers.
    always_comb begin
        rd_data_a_d = regs_q[rd_addr_a];
        rd_data_b_d = regs_q[rd_addr_b];
`ifdef BANCO_REGISTROS_BYPASS_EN
        if (commit_we && (commit_addr == rd_addr_a)) begin
            rd_data_a_d = commit_data;
        end
        if (commit_we && (commit_addr == rd_addr_b)) begin
            rd_data_b_d = commit_data;
        end
`endif
    end

    // Registered read ports: one cycle from address to data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;

endmodule

// File: tb/tb_banco_registros.sv
// Scoreboard bench for banco_registros. Stimulus pushes expected values
// tagged with the cycle in which they must be visible; a monitor on the
// falling edge pops and compares everything due in the current cycle.
module tb_banco_registros;

    localparam int N     = 16;
    localparam int DEPTH = 4;
    localparam int A     = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         we = 1'b0;
    logic         clr = 1'b0;
    logic [A-1:0] wr_addr = '0;
    logic [N-1:0] wr_data = '0;
    logic [A-1:0] rd_addr_a = '0;
    logic [A-1:0] rd_addr_b = '0;
    logic [N-1:0] rd_data_a;
    logic [N-1:0] rd_data_b;
    logic         busy;
    logic         wr_drop;

    banco_registros #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .clr       (clr),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .busy      (busy),
        .wr_drop   (wr_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        int           sel;   // 0 rd_data_a, 1 rd_data_b, 2 busy, 3 wr_drop
        int           due;
        logic [N-1:0] exp;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: compare every entry due this cycle; late entries are errors.
    always @(negedge clk) begin
        int           i;
        logic [N-1:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                case (sb[i].sel)
                    0:       act = rd_data_a;
                    1:       act = rd_data_b;
                    2:       act = N'(busy);
                    default: act = N'(wr_drop);
                endcase
                n_checks++;
                if (act !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got %h, expected %h", sb[i].name, cyc, act, sb[i].exp);
                end else begin
                    $display("ok   %s cyc=%0d: %h", sb[i].name, cyc, act);
                end
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: check missed at cyc=%0d, expected %h", sb[i].name, sb[i].due, sb[i].exp);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input string name, input int sel, input int due, input logic [N-1:0] exp);
        chk_t e;
        e.name = name;
        e.sel  = sel;
        e.due  = due;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Issue a read on both ports; data is due one cycle later.
    task automatic rd(input string name, input logic [A-1:0] aa, input logic [A-1:0] ab,
                      input logic [N-1:0] ea, input logic [N-1:0] eb);
        rd_addr_a = aa;
        rd_addr_b = ab;
        expect_at({name, "_a"}, 0, cyc + 1, ea);
        expect_at({name, "_b"}, 1, cyc + 1, eb);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        int           c;
        logic [N-1:0] same_exp;

        // Reset held: outputs forced low.
        tick();
        expect_at("rst_rd_a", 0, cyc, 16'h0000);
        expect_at("rst_rd_b", 1, cyc, 16'h0000);
        expect_at("rst_busy", 2, cyc, 16'h0000);
        expect_at("rst_wrdrop", 3, cyc, 16'h0000);
        tick();
        rst = 1'b0;

        // Reset map.
        rd("map01", 2'd0, 2'd1, 16'h0002, 16'h0001);
        expect_at("idle_busy", 2, cyc, 16'h0000);
        tick();
        rd("map23", 2'd2, 2'd3, 16'h0000, 16'h0000);
        tick();

        // Write then read on both ports.
        we = 1'b1; wr_addr = 2'd2; wr_data = 16'hBEEF;
        expect_at("wr_nodrop", 3, cyc, 16'h0000);
        rd("pre_wr", 2'd0, 2'd1, 16'h0002, 16'h0001);
        tick();
        we = 1'b0;
        rd("wr_rd", 2'd2, 2'd2, 16'hBEEF, 16'hBEEF);
        tick();

        // Same-cycle write and read of address 3.
`ifdef BANCO_REGISTROS_BYPASS_EN
        same_exp = 16'h1234;
`else
        same_exp = 16'h0000;
`endif
        we = 1'b1; wr_addr = 2'd3; wr_data = 16'h1234;
        rd("same_cyc", 2'd3, 2'd2, same_exp, 16'hBEEF);
        tick();
        we = 1'b0;
        rd("after_same", 2'd3, 2'd3, 16'h1234, 16'h1234);
        tick();

        // Fill with 0xFFFF.
        for (int k = 0; k < DEPTH; k++) begin
            we = 1'b1; wr_addr = A'(k); wr_data = 16'hFFFF;
            tick();
        end
        we = 1'b0;
        rd("fill", 2'd0, 2'd3, 16'hFFFF, 16'hFFFF);
        tick();

        // clr with a concurrent write: write dropped, sweep for 4 cycles.
        c = cyc;
        clr = 1'b1; we = 1'b1; wr_addr = 2'd3; wr_data = 16'hAAAA;
        expect_at("clr_wrdrop", 3, c, 16'h0001);
        expect_at("clr_busy", 2, c, 16'h0000);
        rd("clr_rd", 2'd0, 2'd3, 16'hFFFF, 16'hFFFF);
        for (int k = 1; k <= DEPTH; k++) expect_at("restore_busy", 2, c + k, 16'h0001);
        expect_at("restore_done", 2, c + DEPTH + 1, 16'h0000);
        tick();                                   // c+1, idx 0
        clr = 1'b0; we = 1'b0;
        expect_at("rs_nodrop", 3, cyc, 16'h0000);
        tick();                                   // c+2, idx 1
        rd("mid_restore", 2'd0, 2'd2, 16'h0002, 16'hFFFF);
        tick();                                   // c+3, idx 2
        we = 1'b1; wr_addr = 2'd1; wr_data = 16'h5555;
        expect_at("rs_wrdrop", 3, cyc, 16'h0001);
        rd("rs_rd", 2'd1, 2'd3, 16'h0001, 16'hFFFF);
        tick();                                   // c+4, idx 3, clr ignored
        we = 1'b0; clr = 1'b1;
        expect_at("rs_clr_nodrop", 3, cyc, 16'h0000);
        tick();                                   // c+5, IDLE
        clr = 1'b0;
        rd("post01", 2'd0, 2'd1, 16'h0002, 16'h0001);
        tick();
        rd("post23", 2'd2, 2'd3, 16'h0000, 16'h0000);
        expect_at("post_busy", 2, cyc, 16'h0000);
        tick();

        // Asynchronous reset in the 2nd RESTORE cycle.
        we = 1'b1; wr_addr = 2'd2; wr_data = 16'h7777;
        tick();
        we = 1'b0;
        c = cyc;
        clr = 1'b1;
        rd("pre_arst", 2'd2, 2'd0, 16'h7777, 16'h0002);
        tick();                                   // c+1, first RESTORE cycle
        clr = 1'b0;
        tick();                                   // c+2, second RESTORE cycle
        rst = 1'b1;
        expect_at("arst_busy", 2, cyc, 16'h0000);
        expect_at("arst_rd_a", 0, cyc, 16'h0000);
        expect_at("arst_rd_b", 1, cyc, 16'h0000);
        expect_at("arst_wrdrop", 3, cyc, 16'h0000);
        tick();
        rst = 1'b0;
        rd("arst01", 2'd0, 2'd1, 16'h0002, 16'h0001);
        expect_at("arst_idle", 2, cyc, 16'h0000);
        tick();
        rd("arst23", 2'd2, 2'd3, 16'h0000, 16'h0000);
        tick();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
